// File: rtl/stack_pkg.sv
// Shared types and defaults for the parametrised operand stack.
package stack_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 256;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_REPL,
    OP_TOS
  } stack_op_e;

  // Ceiling log2 evaluated at elaboration time; 1 and 2 both map to 1 bit or less.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/param_stack_if.sv
// Request/response bundle between the control FSM and the operand stack.
interface param_stack_if
  import stack_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int PTR_W  = clog2(DEPTH)
);
  // push/pop/tos are single-cycle request strobes with no backpressure; the stack
  // accepts every request, and d_out_vld is a one-cycle response strobe that marks
  // d_out as freshly loaded on the edge after a successful pop, replace or tos.
  logic              push;
  logic              pop;
  logic              tos;
  logic              clr_err;
  logic [DATA_W-1:0] d_in;
  logic [DATA_W-1:0] d_out;
  logic              d_out_vld;
  logic [PTR_W:0]    count;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;

  modport master (
    output push, pop, tos, clr_err, d_in,
    input  d_out, d_out_vld, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, tos, clr_err, d_in,
    output d_out, d_out_vld, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/stack_ram.sv
// DEPTH x DATA_W storage: synchronous write, asynchronous read (distributed RAM).
module stack_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/param_stack.sv
// Parametrised LIFO operand stack with replace-top, status and sticky error flags.
module param_stack
  import stack_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int PTR_W  = clog2(DEPTH)
) (
  input logic         clk,
  input logic         rst,
  param_stack_if.slave bus
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  stack_op_e         op;
  logic [PTR_W:0]    count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              vld_q, vld_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              ovf_set, unf_set;
  logic              is_empty, is_full;
  logic              we;
  logic [PTR_W-1:0]  top_addr, wr_addr;
  logic [DATA_W-1:0] rd_data;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == FULL_CNT);

  // Low pointer bits are zero when full, so the subtraction still lands on DEPTH-1.
  assign top_addr = count_q[PTR_W-1:0] - PTR_ONE;
  assign wr_addr  = (op == OP_REPL && !is_empty) ? top_addr : count_q[PTR_W-1:0];

  always_comb begin
    op = OP_NONE;
    if (bus.push && bus.pop) op = OP_REPL;
    else if (bus.push)       op = OP_PUSH;
    else if (bus.pop)        op = OP_POP;
    else if (bus.tos)        op = OP_TOS;
  end

  always_comb begin
    count_d = count_q;
    dout_d  = dout_q;
    vld_d   = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    we      = 1'b0;
    case (op)
      OP_REPL: begin
        we = 1'b1;
        if (!is_empty) begin
          dout_d = rd_data;
          vld_d  = 1'b1;
        end else begin
          // Replace on an empty stack degrades to a push but still flags the missing pop.
          count_d = count_q + CNT_ONE;
          unf_set = 1'b1;
        end
      end
      OP_PUSH: begin
        if (!is_full) begin
          we      = 1'b1;
          count_d = count_q + CNT_ONE;
        end else begin
          ovf_set = 1'b1;
        end
      end
      OP_POP: begin
        if (!is_empty) begin
          dout_d  = rd_data;
          vld_d   = 1'b1;
          count_d = count_q - CNT_ONE;
        end else begin
          unf_set = 1'b1;
        end
      end
      OP_TOS: begin
        if (!is_empty) begin
          dout_d = rd_data;
          vld_d  = 1'b1;
        end else begin
          unf_set = 1'b1;
        end
      end
      default: ;
    endcase
    ovf_d = (ovf_q && !bus.clr_err) || ovf_set;
    unf_d = (unf_q && !bus.clr_err) || unf_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  stack_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (we && !rst),
    .waddr_i (wr_addr),
    .wdata_i (bus.d_in),
    .raddr_i (top_addr),
    .rdata_o (rd_data)
  );

  assign bus.count     = count_q;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.d_out     = dout_q;
  assign bus.d_out_vld = vld_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;

endmodule

// File: tb/tb_param_stack.sv
// Bench for param_stack: an 8x4 instance and a 16x256 instance checked against a queue model.
module tb_param_stack;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  param_stack_if #(.DATA_W(8),  .DEPTH(4))   bus_a ();
  param_stack_if #(.DATA_W(16), .DEPTH(256)) bus_b ();

  param_stack #(.DATA_W(8), .DEPTH(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  param_stack #(.DATA_W(16), .DEPTH(256)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a plain LIFO queue plus the flags and output register
  logic [15:0] mq[$];
  int          m_depth = 4;
  logic [15:0] m_mask  = 16'h00FF;
  logic [15:0] m_dout  = '0;
  bit          m_vld   = 1'b0;
  bit          m_ovf   = 1'b0;
  bit          m_unf   = 1'b0;
  bit          sel     = 1'b0;

  logic [31:0] act_dout, act_count;
  logic        act_vld, act_empty, act_full, act_ovf, act_unf;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit p, input bit o, input bit t, input bit c,
                            input logic [15:0] din);
    bit          ovf_set;
    bit          unf_set;
    logic [15:0] d;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    d       = din & m_mask;
    m_vld   = 1'b0;
    if (r) begin
      mq.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      return;
    end
    if (p && o) begin
      if (mq.size() > 0) begin
        m_dout = mq[mq.size()-1];
        mq[mq.size()-1] = d;
        m_vld = 1'b1;
      end else begin
        mq.push_back(d);
        unf_set = 1'b1;
      end
    end else if (p) begin
      if (mq.size() < m_depth) mq.push_back(d);
      else ovf_set = 1'b1;
    end else if (o) begin
      if (mq.size() > 0) begin
        m_dout = mq.pop_back();
        m_vld  = 1'b1;
      end else unf_set = 1'b1;
    end else if (t) begin
      if (mq.size() > 0) begin
        m_dout = mq[mq.size()-1];
        m_vld  = 1'b1;
      end else unf_set = 1'b1;
    end
    m_ovf = (m_ovf && !c) || ovf_set;
    m_unf = (m_unf && !c) || unf_set;
  endtask

  task automatic drive(input bit p, input bit o, input bit t, input bit c, input logic [15:0] din);
    bus_a.push = 1'b0; bus_a.pop = 1'b0; bus_a.tos = 1'b0; bus_a.clr_err = 1'b0; bus_a.d_in = '0;
    bus_b.push = 1'b0; bus_b.pop = 1'b0; bus_b.tos = 1'b0; bus_b.clr_err = 1'b0; bus_b.d_in = '0;
    if (!sel) begin
      bus_a.push = p; bus_a.pop = o; bus_a.tos = t; bus_a.clr_err = c; bus_a.d_in = din[7:0];
    end else begin
      bus_b.push = p; bus_b.pop = o; bus_b.tos = t; bus_b.clr_err = c; bus_b.d_in = din;
    end
  endtask

  // One request cycle: drive at negedge, model on posedge, compare at the next negedge.
  task automatic cycle(input bit r, input bit p, input bit o, input bit t, input bit c,
                       input logic [15:0] din);
    rst = r;
    drive(p, o, t, c, din);
    @(posedge clk);
    model_step(r, p, o, t, c, din);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    if (!sel) begin
      act_dout = 32'(bus_a.d_out);  act_count = 32'(bus_a.count); act_vld = bus_a.d_out_vld;
      act_empty = bus_a.empty; act_full = bus_a.full; act_ovf = bus_a.overflow; act_unf = bus_a.underflow;
    end else begin
      act_dout = 32'(bus_b.d_out);  act_count = 32'(bus_b.count); act_vld = bus_b.d_out_vld;
      act_empty = bus_b.empty; act_full = bus_b.full; act_ovf = bus_b.overflow; act_unf = bus_b.underflow;
    end
    check("count",     act_count,        32'(mq.size()));
    check("empty",     32'(act_empty),   32'(mq.size() == 0));
    check("full",      32'(act_full),    32'(mq.size() == m_depth));
    check("overflow",  32'(act_ovf),     32'(m_ovf));
    check("underflow", 32'(act_unf),     32'(m_unf));
    check("d_out_vld", 32'(act_vld),     32'(m_vld));
    check("d_out",     act_dout,         32'(m_dout));
  endtask

  task automatic do_push(input logic [15:0] d); cycle(0, 1, 0, 0, 0, d); endtask
  task automatic do_pop();                      cycle(0, 0, 1, 0, 0, 16'h0); endtask
  task automatic do_tos();                      cycle(0, 0, 0, 1, 0, 16'h0); endtask
  task automatic do_rst();                      cycle(1, 0, 0, 0, 0, 16'h0); endtask

  initial begin
    logic [7:0] exp_pops [4];
    exp_pops[0] = 8'h44; exp_pops[1] = 8'h33; exp_pops[2] = 8'h22; exp_pops[3] = 8'h11;
    drive(0, 0, 0, 0, 16'h0);
    @(negedge clk);

    // Fill, overflow, drain
    sel = 1'b0; m_depth = 4; m_mask = 16'h00FF;
    do_rst();
    do_push(16'h11); do_push(16'h22); do_push(16'h33); do_push(16'h44);
    check("fill_full", 32'(act_full), 32'd1);
    do_push(16'h55);
    check("push_full_ovf", 32'(act_ovf), 32'd1);
    check("push_full_cnt", act_count, 32'd4);
    for (int i = 0; i < 4; i++) begin
      do_pop();
      check("drain_val", act_dout, 32'(exp_pops[i]));
      check("drain_vld", 32'(act_vld), 32'd1);
    end
    check("drain_empty", 32'(act_empty), 32'd1);

    // Underflow and clear
    do_rst();
    do_pop(); do_tos();
    check("unf_set", 32'(act_unf), 32'd1);
    check("unf_dout_hold", act_dout, 32'd0);
    cycle(0, 0, 0, 0, 1, 16'h0);
    check("unf_clr", 32'(act_unf), 32'd0);
    cycle(0, 0, 1, 0, 1, 16'h0);
    check("unf_set_wins", 32'(act_unf), 32'd1);

    // Replace-top, including while full
    do_rst();
    do_push(16'hA0); do_push(16'hB0);
    cycle(0, 1, 1, 0, 0, 16'hC0);
    check("repl_val", act_dout, 32'hB0);
    check("repl_cnt", act_count, 32'd2);
    do_tos();
    check("repl_tos", act_dout, 32'hC0);
    do_push(16'hD0); do_push(16'hE0);
    cycle(0, 1, 1, 0, 0, 16'hF0);
    check("repl_full_val", act_dout, 32'hE0);
    check("repl_full_ovf", 32'(act_ovf), 32'd0);
    cycle(0, 1, 1, 0, 0, 16'h12);
    check("repl_empty_push", act_count, 32'd4);

    // Peek and pop+tos
    do_rst();
    do_push(16'h5A); do_tos(); do_tos();
    check("tos_val", act_dout, 32'h5A);
    check("tos_cnt", act_count, 32'd1);
    cycle(0, 0, 1, 1, 0, 16'h0);
    check("pop_tos_cnt", act_count, 32'd0);

    // Reset mid-sequence with push high
    do_push(16'h01); do_push(16'h02); do_push(16'h03);
    cycle(1, 1, 0, 0, 0, 16'h99);
    check("rst_cnt", act_count, 32'd0);
    check("rst_dout", act_dout, 32'd0);
    do_push(16'h77); do_pop();
    check("post_rst_pop", act_dout, 32'h77);

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      bit r, p, o, t, c;
      r = ($urandom_range(0, 59) == 0);
      p = ($urandom_range(0, 2) == 0);
      o = ($urandom_range(0, 2) == 0);
      t = ($urandom_range(0, 3) == 0);
      c = ($urandom_range(0, 7) == 0);
      cycle(r, p, o, t, c, 16'($urandom_range(0, 255)));
    end

    // Deep, wide instance: fill, drain, no wrap
    sel = 1'b1; m_depth = 256; m_mask = 16'hFFFF;
    do_rst();
    for (int i = 0; i < 256; i++) do_push(16'(i));
    check("deep_full", 32'(act_full), 32'd1);
    check("deep_cnt", act_count, 32'd256);
    for (int i = 255; i >= 0; i--) begin
      do_pop();
      check("deep_pop", act_dout, 32'(i));
    end
    check("deep_empty", act_count, 32'd0);
    do_pop();
    check("deep_nowrap", act_count, 32'd0);
    check("deep_unf", 32'(act_unf), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/param_stack.md
Name: param_stack

Overview:
- Parametrised LIFO stack; successor to the fixed 8-bit × 256 operand stack in the stack-based processor datapath.
- Adds configurable width and depth, full/empty/count status, and an atomic replace-top operation (push+pop in the same cycle).
- Adds sticky overflow/underflow error flags and a registered read-valid strobe.
- Sits between the control FSM, which issues the push/pop/tos strobes, and the ALU/memory operand buses.

Parameters:
- DATA_W, 8, data word width in bits.
- DEPTH, 256, number of stack entries; must be a power of two and ≥ 2.
- PTR_W, $clog2(DEPTH), pointer width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- push  in  1  write d_in at the top of stack.
- pop  in  1  remove the top entry and return it on d_out.
- tos  in  1  read the top entry without removing it.
- clr_err  in  1  clear the sticky error flags.
- d_in  in  DATA_W  push data.
- d_out  out  DATA_W  registered read data.
- d_out_vld  out  1  one-cycle pulse: d_out updated this cycle.
- count  out  PTR_W+1  number of valid entries, 0..DEPTH.
- empty  out  1  count == 0 (combinational from count).
- full  out  1  count == DEPTH (combinational from count).
- overflow  out  1  sticky: a push was rejected because the stack was full.
- underflow  out  1  sticky: a pop or tos was issued while the stack was empty.

Behaviour:
- Reset, synchronous, on a clk edge with rst=1:
  - count=0, d_out=0, d_out_vld=0, overflow=0, underflow=0.
  - Storage array is not cleared.
  - rst overrides every other input in that cycle.
- Top entry is at index count-1; storage writes are synchronous; all outputs are registered.
- Operation per cycle, highest priority first:
  1. push&pop, count>0 (replace): d_out<=mem[count-1]; mem[count-1]<=d_in; count unchanged; d_out_vld=1. Allowed when full; no overflow.
  2. push&pop, count==0: treated as a plain push; underflow<=1; d_out_vld=0.
  3. push only, count<DEPTH: mem[count]<=d_in; count<=count+1.
  4. push only, count==DEPTH: write dropped; count unchanged; overflow<=1.
  5. pop only, count>0: d_out<=mem[count-1]; count<=count-1; d_out_vld=1.
  6. pop only, count==0: no state change except underflow<=1; d_out holds.
  7. tos (with no push/pop), count>0: d_out<=mem[count-1]; d_out_vld=1.
  8. tos (with no push/pop), count==0: underflow<=1; d_out holds.
  9. tos asserted together with push and/or pop: tos is ignored.
- Latency: d_out and d_out_vld are valid on the clock edge after the request cycle (1 cycle).
- A push followed by a pop on the next cycle returns the pushed value; write-to-read forwarding is by array timing, with no bypass needed.
- The count edge DEPTH→DEPTH-1 on pop clears full; count never wraps.
- clr_err clears overflow and underflow.
  - If a new error occurs in the same cycle, set wins over clear.
- d_out_vld deasserts on any cycle without a successful read.

Decomposition:
- Package stack_pkg:
  - localparam defaults DATA_W_DEF=8, DEPTH_DEF=256.
  - Function clog2 for tools lacking $clog2.
  - Enum stack_op_e {OP_NONE, OP_PUSH, OP_POP, OP_REPL, OP_TOS}.
- The top level decodes push/pop/tos into stack_op_e combinationally, then a single case drives count/d_out/flags.
- One sub-module: stack_ram, holding DEPTH × DATA_W storage.
  - Ports: write enable, write address, write data, asynchronous read address and data.
  - Keeps the storage inferable as distributed RAM and separate from the control logic.

Test Plan (DATA_W=8, DEPTH=4 unless noted):
- Reset then push 0x11,0x22,0x33,0x44.
  - count=4, full=1.
  - A 5th push of 0x55 sets overflow=1 and leaves count=4.
  - Then pop ×4 returns 0x44,0x33,0x22,0x11, each with a d_out_vld pulse one cycle after the request; empty=1 at the end.
- Empty stack: pop, then tos.
  - underflow=1, d_out_vld=0, d_out unchanged, count=0.
  - clr_err → underflow=0 on the next cycle.
  - clr_err together with a pop on empty keeps underflow=1.
- Push 0xA0,0xB0, then push&pop with d_in=0xC0.
  - d_out=0xB0, d_out_vld=1, count=2.
  - tos then returns 0xC0.
  - Repeat the same replace while full: no overflow.
- Push 0x5A, then tos twice.
  - d_out=0x5A on both, count stays 1.
  - pop+tos together acts as a pop only: count=0.
- Assert rst mid-sequence with count=3 and push also high.
  - Next cycle: count=0, all flags 0, d_out=0.
  - A subsequent push 0x77 then pop returns 0x77.
- DATA_W=16, DEPTH=256:
  - Push 256 incrementing words → full=1.
  - Pop all 256 → values 0x00FF..0x0000 in order; count ends at 0 with no wrap.
